stack_ctrl: RTL and testbench
=============================

# stack_ctrl

Sequencer for the processor's operand stack. It translates the control unit's single-cycle push/pop/tos strobes into accesses on an external synchronous single-port stack RAM. It owns the stack pointer, full/empty status and sticky error flags, and zero-fills the RAM after reset or on request. It sits between the control unit and the stack RAM, and its read data feeds the ALU operand registers and the memory write path.

## Interface
- DEPTH, 16, number of stack entries; must be a power of two, DEPTH = 2**AW
- AW, 4, RAM address width
- WIDTH, 8, data width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- push  in  1  write din to the new top of stack
- pop  in  1  read the top of stack and remove it
- tos  in  1  read the top of stack without removing it
- clr  in  1  empty the stack and restart the zero-fill sweep
- din  in  WIDTH  push data
- dout  out  WIDTH  read data
- rvalid  out  1  dout carries fresh read data this cycle
- sp  out  AW+1  entry count, 0..DEPTH
- empty, full  out  1  sp==0 / sp==DEPTH
- busy  out  1  zero-fill sweep in progress; commands ignored
- ovf_err, unf_err, cmd_err  out  1  sticky: push on full / pop or tos on empty / multi-hot command
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  WIDTH  RAM write data
- ram_rdata  in  WIDTH  RAM read data, valid one cycle after the address

## Operation
- States: INIT (zero-fill sweep) and RUN.
- Reset: state=INIT, clr_cnt=0, sp=0, all error flags=0, rvalid=0, dout register=0.
  - All ram_* outputs are forced to 0 while rst is high.
- INIT, each cycle:
  - Drive ram_addr=clr_cnt, ram_we=1, ram_wdata=0, busy=1.
  - At the clock edge, clr_cnt increments.
  - On the edge where clr_cnt==DEPTH-1, move to RUN.
- clr in RUN: sp becomes 0, clr_cnt becomes 0, state moves to INIT. Error flags keep their values.
  - clr has priority over a simultaneous command; that command is dropped with no error set.
- clr in INIT: the sweep restarts at address 0.
- RUN, command decode. Exactly one of push/pop/tos may be high in a cycle.
  - Zero high: idle; ram_we=0.
  - Two or more high: nothing executes and cmd_err is set.
- push:
  - sp<DEPTH: ram_addr=sp[AW-1:0], ram_we=1, ram_wdata=din, sp+1.
  - sp==DEPTH: no write, sp unchanged, ovf_err set.
- pop:
  - sp>0: ram_addr=sp-1, ram_we=0, sp-1, read issued.
  - sp==0: no read, unf_err set.
- tos: same as pop except sp is unchanged.
- Read return:
  - In the cycle after an issued read, rvalid=1 and dout=ram_rdata (combinational pass-through).
  - ram_rdata is also captured into the dout register on that edge.
  - Whenever rvalid=0, dout shows the held register value.
- Commands in INIT are ignored and set no error flag.
- rvalid pipeline from a read issued in the last RUN cycle before clr still completes.
- Error flags clear only on rst.
- Address arithmetic: sp-1 and sp are truncated to AW bits; sp itself never wraps.

## Timing
- After rst deasserts, busy stays high for exactly DEPTH cycles. The first accepted command is in cycle DEPTH (counting from 0).
- push: sp updates at the edge ending the command cycle N. The data is readable by a pop or tos issued in cycle N+1.
- pop/tos issued in cycle N: rvalid and dout are valid in cycle N+1.
- Back-to-back reads in N and N+1 return in N+1 and N+2. Full throughput is one command per cycle with no bubbles.
- push in N+1 after a pop in N is legal. The write occurs while the read data from N returns.
- empty, full and sp are registered-state decodes. They reflect all commands up to the previous edge.
- Reset mid-sweep or mid-read: everything returns to reset values immediately, rvalid drops, and the sweep restarts.

## Test plan
- Reset, DEPTH=16 -> busy high for 16 cycles; ram_we=1 with addresses 0..15 and wdata 0; then busy=0, sp=0, empty=1.
- push 0x11, 0x22, then pop, pop -> ram writes to addr 0 and 1; rvalid with dout=0x22 then 0x11 on consecutive cycles; sp returns to 0, empty=1.
- 16 pushes of 0x00..0x0F, then a 17th push of 0xFF -> full=1, sp=16, no write, ovf_err=1; then tos -> dout=0x0F, sp stays 16.
- pop on empty -> unf_err=1, rvalid stays 0, dout holds its previous value; then push+pop in the same cycle -> cmd_err=1, sp unchanged.
- With sp=5, assert clr -> sp=0, busy=1 for 16 cycles, errors retained; pulse rst at sweep address 7 -> sweep restarts at 0 and all flags clear.

Source files
------------

// File: rtl/stack_ctrl.sv
// Operand-stack sequencer: turns push/pop/tos strobes into single-port stack RAM
// accesses, tracks the stack pointer and sticky errors, and zero-fills the RAM.
module stack_ctrl #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             tos,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             rvalid,
   output logic [AW:0]      sp,
   output logic             empty,
   output logic             full,
   output logic             busy,
   output logic             ovf_err,
   output logic             unf_err,
   output logic             cmd_err,
   output logic [AW-1:0]    ram_addr,
   output logic             ram_we,
   output logic [WIDTH-1:0] ram_wdata,
   input  logic [WIDTH-1:0] ram_rdata
);

   // state  | meaning
   // S_INIT | zero-fill sweep over every RAM address, commands ignored
   // S_RUN  | normal command decode
   typedef enum logic {S_INIT, S_RUN} state_e;

   localparam logic [AW:0]   SP_FULL  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH-1);

   state_e           state_q, state_d;
   logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
   logic [AW:0]      sp_q, sp_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             cmd_q, cmd_d;
   logic             rvalid_q, rvalid_d;
   logic [WIDTH-1:0] dout_q, dout_d;

   logic             we_c;
   logic [AW-1:0]    addr_c;
   logic [WIDTH-1:0] wdata_c;
   logic [1:0]       n_cmd;

   assign n_cmd = {1'b0, push} + {1'b0, pop} + {1'b0, tos};

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      sp_d      = sp_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      cmd_d     = cmd_q;
      rvalid_d  = 1'b0;
      dout_d    = rvalid_q ? ram_rdata : dout_q;
      we_c      = 1'b0;
      addr_c    = sp_q[AW-1:0];
      wdata_c   = din;
      case (state_q)
         S_INIT: begin
            we_c    = 1'b1;
            addr_c  = clr_cnt_q;
            wdata_c = '0;
            if (clr) begin
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
               if (clr_cnt_q == CNT_LAST) state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (clr) begin
               sp_d      = '0;
               clr_cnt_d = '0;
               state_d   = S_INIT;
            end else if (n_cmd > 2'd1) begin
               cmd_d = 1'b1;
            end else if (push) begin
               if (sp_q == SP_FULL) begin
                  ovf_d = 1'b1;
               end else begin
                  we_c = 1'b1;
                  sp_d = sp_q + 1'b1;
               end
            end else if (pop || tos) begin
               if (sp_q == '0) begin
                  unf_d = 1'b1;
               end else begin
                  addr_c   = sp_q[AW-1:0] - 1'b1;
                  rvalid_d = 1'b1;
                  if (pop) sp_d = sp_q - 1'b1;
               end
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_INIT;
         clr_cnt_q <= '0;
         sp_q      <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         cmd_q     <= 1'b0;
         rvalid_q  <= 1'b0;
         dout_q    <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         sp_q      <= sp_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         cmd_q     <= cmd_d;
         rvalid_q  <= rvalid_d;
         dout_q    <= dout_d;
      end
   end

   // RAM strobes are gated by rst directly so nothing is written while reset is held.
   assign ram_we    = we_c & ~rst;
   assign ram_addr  = rst ? '0 : addr_c;
   assign ram_wdata = rst ? '0 : wdata_c;

   assign dout    = rvalid_q ? ram_rdata : dout_q;
   assign rvalid  = rvalid_q;
   assign sp      = sp_q;
   assign empty   = (sp_q == '0);
   assign full    = (sp_q == SP_FULL);
   assign busy    = (state_q == S_INIT);
   assign ovf_err = ovf_q;
   assign unf_err = unf_q;
   assign cmd_err = cmd_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed scenarios plus random traffic, each checked
// against a queue-based stack model and a behavioural synchronous RAM.
module tb_stack_ctrl;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             push = 1'b0, pop = 1'b0, tos = 1'b0, clr = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic [WIDTH-1:0] dout;
   logic             rvalid, empty, full, busy, ovf_err, unf_err, cmd_err;
   logic [AW:0]      sp;
   logic [AW-1:0]    ram_addr;
   logic             ram_we;
   logic [WIDTH-1:0] ram_wdata;
   logic [WIDTH-1:0] ram_rdata = '0;

   logic [WIDTH-1:0] mem [DEPTH];

   int n_cmp = 0;
   int n_bad = 0;

   stack_ctrl #(.DEPTH(DEPTH), .AW(AW), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .clr(clr),
      .din(din), .dout(dout), .rvalid(rvalid), .sp(sp), .empty(empty),
      .full(full), .busy(busy), .ovf_err(ovf_err), .unf_err(unf_err),
      .cmd_err(cmd_err), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // synchronous single-port RAM, read data one cycle after the address
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   // reference model
   int               stk[$];
   bit               m_busy;
   int               m_cnt;
   bit               m_ovf, m_unf, m_cmd, m_rv;
   logic [WIDTH-1:0] m_rdata, m_hold;

   // per-cycle expected values and DUT snapshot, both taken before the edge
   logic             e_busy, e_empty, e_full, e_ovf, e_unf, e_cmd, e_rv, e_we, e_acheck;
   logic [AW:0]      e_sp;
   logic [WIDTH-1:0] e_dout, e_wdata;
   logic [AW-1:0]    e_addr;
   logic             o_busy, o_empty, o_full, o_ovf, o_unf, o_cmd, o_rv, o_we;
   logic [AW:0]      o_sp;
   logic [WIDTH-1:0] o_dout, o_wdata;
   logic [AW-1:0]    o_addr;

   task automatic model_reset();
      stk.delete();
      m_busy = 1; m_cnt = 0;
      m_ovf = 0; m_unf = 0; m_cmd = 0; m_rv = 0;
      m_rdata = '0; m_hold = '0;
   endtask

   task automatic step(input logic pu, input logic po, input logic to,
                       input logic cl, input logic [WIDTH-1:0] d);
      int sz;
      bit nrv;
      @(negedge clk);
      push = pu; pop = po; tos = to; clr = cl; din = d;
      #1;
      sz = stk.size();
      e_busy = m_busy; e_sp = (AW+1)'(sz); e_empty = (sz == 0); e_full = (sz == DEPTH);
      e_ovf = m_ovf; e_unf = m_unf; e_cmd = m_cmd; e_rv = m_rv;
      e_dout = m_rv ? m_rdata : m_hold;
      e_we = 0; e_acheck = 0; e_addr = '0; e_wdata = '0;
      if (m_busy) begin
         e_we = 1; e_acheck = 1; e_addr = AW'(m_cnt); e_wdata = '0;
      end else if (!cl && (int'(pu) + int'(po) + int'(to)) == 1) begin
         if (pu && sz < DEPTH) begin
            e_we = 1; e_acheck = 1; e_addr = AW'(sz); e_wdata = d;
         end else if ((po || to) && sz > 0) begin
            e_acheck = 1; e_addr = AW'(sz - 1);
         end
      end
      o_busy = busy; o_sp = sp; o_empty = empty; o_full = full;
      o_ovf = ovf_err; o_unf = unf_err; o_cmd = cmd_err; o_rv = rvalid;
      o_dout = dout; o_we = ram_we; o_addr = ram_addr; o_wdata = ram_wdata;
      @(posedge clk);
      if (m_rv) m_hold = m_rdata;
      nrv = 0;
      if (m_busy) begin
         if (cl) m_cnt = 0;
         else if (m_cnt == DEPTH - 1) m_busy = 0;
         else m_cnt++;
      end else if (cl) begin
         stk.delete(); m_busy = 1; m_cnt = 0;
      end else if ((int'(pu) + int'(po) + int'(to)) > 1) begin
         m_cmd = 1;
      end else if (pu) begin
         if (sz == DEPTH) m_ovf = 1;
         else stk.push_back(int'(d));
      end else if (po || to) begin
         if (sz == 0) m_unf = 1;
         else begin
            m_rdata = WIDTH'(stk[$]);
            nrv = 1;
            if (po) void'(stk.pop_back());
         end
      end
      m_rv = nrv;
      #1;
      push = 0; pop = 0; tos = 0; clr = 0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(8'hA0 + i);
      rst = 1; din = 8'hFF;
      repeat (3) @(posedge clk);
      #2;
      n_cmp++;
      if ({ram_we, ram_addr, ram_wdata} !== '0) begin
         n_bad++; $display("FAIL rst_ram_forced: we=%0b addr=%0d wdata=%h required 0/0/00", ram_we, ram_addr, ram_wdata);
      end
      n_cmp++;
      if ({sp, rvalid, dout, ovf_err, unf_err, cmd_err} !== '0 || busy !== 1'b1) begin
         n_bad++; $display("FAIL rst_state: sp=%0d rv=%0b dout=%h err=%b%b%b busy=%0b required 0/0/00/000/1",
                           sp, rvalid, dout, ovf_err, unf_err, cmd_err, busy);
      end
      model_reset();
      @(posedge clk); #1; rst = 0; din = '0;
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 0, 0, 0, 8'h00);
         n_cmp++;
         if ({o_busy, o_we, o_addr, o_wdata} !== {1'b1, 1'b1, AW'(i), 8'h00}) begin
            n_bad++; $display("FAIL sweep_%0d: busy=%0b we=%0b addr=%0d wdata=%h required 1/1/%0d/00",
                              i, o_busy, o_we, o_addr, o_wdata, i);
         end
      end
      step(0, 0, 0, 0, 8'h00);
      n_cmp++;
      if ({o_busy, o_sp, o_empty} !== {1'b0, 5'd0, 1'b1}) begin
         n_bad++; $display("FAIL post_sweep: busy=%0b sp=%0d empty=%0b required 0/0/1", o_busy, o_sp, o_empty);
      end
      for (int i = 0; i < DEPTH; i++) begin
         n_cmp++;
         if (mem[i] !== 8'h00) begin
            n_bad++; $display("FAIL zero_fill_%0d: mem=%h required 00", i, mem[i]);
         end
      end
   endtask

   task automatic test_push_pop();
      step(1, 0, 0, 0, 8'h11);
      n_cmp++;
      if ({o_we, o_addr, o_wdata} !== {1'b1, 4'd0, 8'h11}) begin
         n_bad++; $display("FAIL push1: we=%0b addr=%0d wdata=%h required 1/0/11", o_we, o_addr, o_wdata);
      end
      step(1, 0, 0, 0, 8'h22);
      n_cmp++;
      if ({o_we, o_addr, o_wdata} !== {1'b1, 4'd1, 8'h22}) begin
         n_bad++; $display("FAIL push2: we=%0b addr=%0d wdata=%h required 1/1/22", o_we, o_addr, o_wdata);
      end
      step(0, 1, 0, 0, 8'h00);
      n_cmp++;
      if ({o_we, o_addr, o_sp} !== {1'b0, 4'd1, 5'd2}) begin
         n_bad++; $display("FAIL pop1_issue: we=%0b addr=%0d sp=%0d required 0/1/2", o_we, o_addr, o_sp);
      end
      step(0, 1, 0, 0, 8'h00);
      n_cmp++;
      if ({o_rv, o_dout, o_addr} !== {1'b1, 8'h22, 4'd0}) begin
         n_bad++; $display("FAIL pop1_data: rv=%0b dout=%h addr=%0d required 1/22/0", o_rv, o_dout, o_addr);
      end
      step(0, 0, 0, 0, 8'h00);
      n_cmp++;
      if ({o_rv, o_dout, o_sp, o_empty} !== {1'b1, 8'h11, 5'd0, 1'b1}) begin
         n_bad++; $display("FAIL pop2_data: rv=%0b dout=%h sp=%0d empty=%0b required 1/11/0/1", o_rv, o_dout, o_sp, o_empty);
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, WIDTH'(i));
      step(1, 0, 0, 0, 8'hFF);
      n_cmp++;
      if ({o_full, o_sp, o_we} !== {1'b1, 5'd16, 1'b0}) begin
         n_bad++; $display("FAIL push_on_full: full=%0b sp=%0d we=%0b required 1/16/0", o_full, o_sp, o_we);
      end
      step(0, 0, 1, 0, 8'h00);
      n_cmp++;
      if ({o_ovf, o_addr, o_sp} !== {1'b1, 4'd15, 5'd16}) begin
         n_bad++; $display("FAIL ovf_tos_issue: ovf=%0b addr=%0d sp=%0d required 1/15/16", o_ovf, o_addr, o_sp);
      end
      step(0, 0, 0, 0, 8'h00);
      n_cmp++;
      if ({o_rv, o_dout, o_sp} !== {1'b1, 8'h0F, 5'd16}) begin
         n_bad++; $display("FAIL tos_full_data: rv=%0b dout=%h sp=%0d required 1/0f/16", o_rv, o_dout, o_sp);
      end
      for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00);
   endtask

   task automatic test_errors();
      step(1, 0, 0, 0, 8'h5A);
      step(0, 1, 0, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00);
      step(0, 1, 0, 0, 8'h00);
      n_cmp++;
      if (o_we !== 1'b0) begin
         n_bad++; $display("FAIL pop_empty_we: we=%0b required 0", o_we);
      end
      step(0, 0, 0, 0, 8'h00);
      n_cmp++;
      if ({o_unf, o_rv, o_dout} !== {1'b1, 1'b0, 8'h5A}) begin
         n_bad++; $display("FAIL pop_empty: unf=%0b rv=%0b dout=%h required 1/0/5a", o_unf, o_rv, o_dout);
      end
      step(1, 1, 0, 0, 8'h77);
      n_cmp++;
      if (o_we !== 1'b0) begin
         n_bad++; $display("FAIL multi_hot_we: we=%0b required 0", o_we);
      end
      step(0, 0, 0, 0, 8'h00);
      n_cmp++;
      if ({o_cmd, o_sp, o_empty} !== {1'b1, 5'd0, 1'b1}) begin
         n_bad++; $display("FAIL multi_hot: cmd=%0b sp=%0d empty=%0b required 1/0/1", o_cmd, o_sp, o_empty);
      end
   endtask

   task automatic test_back_to_back();
      step(1, 0, 0, 0, 8'hA1);
      step(1, 0, 0, 0, 8'hB2);
      step(1, 0, 0, 0, 8'hC3);
      step(0, 1, 0, 0, 8'h00);
      step(0, 1, 0, 0, 8'h00);
      n_cmp++;
      if ({o_rv, o_dout} !== {1'b1, 8'hC3}) begin
         n_bad++; $display("FAIL b2b_first: rv=%0b dout=%h required 1/c3", o_rv, o_dout);
      end
      step(1, 0, 0, 0, 8'hD4);
      n_cmp++;
      if ({o_rv, o_dout, o_we, o_addr, o_wdata} !== {1'b1, 8'hB2, 1'b1, 4'd1, 8'hD4}) begin
         n_bad++; $display("FAIL b2b_push_during_read: rv=%0b dout=%h we=%0b addr=%0d wdata=%h required 1/b2/1/1/d4",
                           o_rv, o_dout, o_we, o_addr, o_wdata);
      end
      step(0, 0, 1, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00);
      n_cmp++;
      if ({o_rv, o_dout, o_sp} !== {1'b1, 8'hD4, 5'd2}) begin
         n_bad++; $display("FAIL b2b_tos: rv=%0b dout=%h sp=%0d required 1/d4/2", o_rv, o_dout, o_sp);
      end
      step(0, 1, 0, 0, 8'h00);
      step(0, 1, 0, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00);
   endtask

   task automatic test_clr();
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, WIDTH'(8'h30 + i));
      step(0, 0, 0, 1, 8'h00);
      n_cmp++;
      if ({o_sp, o_busy} !== {5'd5, 1'b0}) begin
         n_bad++; $display("FAIL clr_pre: sp=%0d busy=%0b required 5/0", o_sp, o_busy);
      end
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 0, 0, 0, 8'h00);
         n_cmp++;
         if ({o_busy, o_we, o_addr, o_sp, o_ovf, o_unf, o_cmd} !== {1'b1, 1'b1, AW'(i), 5'd0, 3'b111}) begin
            n_bad++; $display("FAIL clr_sweep_%0d: busy=%0b we=%0b addr=%0d sp=%0d err=%b%b%b required 1/1/%0d/0/111",
                              i, o_busy, o_we, o_addr, o_sp, o_ovf, o_unf, o_cmd, i);
         end
      end
      step(0, 0, 0, 0, 8'h00);
      n_cmp++;
      if (o_busy !== 1'b0) begin
         n_bad++; $display("FAIL clr_done: busy=%0b required 0", o_busy);
      end
      step(0, 0, 0, 1, 8'h00);
      step(0, 0, 0, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00);
      step(0, 0, 0, 1, 8'h00);
      step(1, 0, 0, 0, 8'h99);
      n_cmp++;
      if ({o_busy, o_addr, o_wdata} !== {1'b1, 4'd0, 8'h00}) begin
         n_bad++; $display("FAIL clr_in_init: busy=%0b addr=%0d wdata=%h required 1/0/00", o_busy, o_addr, o_wdata);
      end
   endtask

   task automatic test_rst_mid_sweep();
      for (int i = 1; i < 7; i++) step(0, 0, 0, 0, 8'h00);
      #2;
      n_cmp++;
      if (ram_addr !== 4'd7) begin
         n_bad++; $display("FAIL pre_rst_addr: addr=%0d required 7", ram_addr);
      end
      rst = 1;
      #1;
      n_cmp++;
      if ({ram_we, ram_addr, sp, ovf_err, unf_err, cmd_err, rvalid, dout} !== '0) begin
         n_bad++; $display("FAIL rst_mid_sweep: we=%0b addr=%0d sp=%0d err=%b%b%b rv=%0b dout=%h required all 0",
                           ram_we, ram_addr, sp, ovf_err, unf_err, cmd_err, rvalid, dout);
      end
      model_reset();
      @(posedge clk); @(posedge clk); #1; rst = 0;
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 0, 0, 0, 8'h00);
         n_cmp++;
         if ({o_busy, o_we, o_addr} !== {1'b1, 1'b1, AW'(i)}) begin
            n_bad++; $display("FAIL resweep_%0d: busy=%0b we=%0b addr=%0d required 1/1/%0d", i, o_busy, o_we, o_addr, i);
         end
      end
   endtask

   task automatic test_random();
      logic pu, po, to, cl;
      int r;
      logic [2:0] mh;
      for (int n = 0; n < 800; n++) begin
         r = $urandom_range(0, 99);
         pu = 0; po = 0; to = 0; cl = 0;
         if (r < 2) cl = 1;
         else if (r < 7) begin
            mh = 3'($urandom_range(0, 3));
            case (mh)
               3'd0: {pu, po, to} = 3'b110;
               3'd1: {pu, po, to} = 3'b101;
               3'd2: {pu, po, to} = 3'b011;
               default: {pu, po, to} = 3'b111;
            endcase
         end
         else if (r < 50) pu = 1;
         else if (r < 80) po = 1;
         else if (r < 92) to = 1;
         step(pu, po, to, cl, WIDTH'($urandom));
         n_cmp++;
         if ({o_busy, o_sp, o_empty, o_full, o_ovf, o_unf, o_cmd} !== {e_busy, e_sp, e_empty, e_full, e_ovf, e_unf, e_cmd}) begin
            n_bad++; $display("FAIL rnd_status_%0d: busy/sp/empty/full/err=%0b/%0d/%0b/%0b/%b%b%b required %0b/%0d/%0b/%0b/%b%b%b",
                              n, o_busy, o_sp, o_empty, o_full, o_ovf, o_unf, o_cmd,
                              e_busy, e_sp, e_empty, e_full, e_ovf, e_unf, e_cmd);
         end
         n_cmp++;
         if ({o_rv, o_dout} !== {e_rv, e_dout}) begin
            n_bad++; $display("FAIL rnd_read_%0d: rv=%0b dout=%h required %0b/%h", n, o_rv, o_dout, e_rv, e_dout);
         end
         n_cmp++;
         if (o_we !== e_we) begin
            n_bad++; $display("FAIL rnd_we_%0d: we=%0b required %0b", n, o_we, e_we);
         end
         if (e_acheck) begin
            n_cmp++;
            if (o_addr !== e_addr) begin
               n_bad++; $display("FAIL rnd_addr_%0d: addr=%0d required %0d", n, o_addr, e_addr);
            end
         end
         if (e_we) begin
            n_cmp++;
            if (o_wdata !== e_wdata) begin
               n_bad++; $display("FAIL rnd_wdata_%0d: wdata=%h required %h", n, o_wdata, e_wdata);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_full();
      test_errors();
      test_back_to_back();
      test_clr();
      test_rst_mid_sweep();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion before 1000000");
      $fatal(1, "watchdog expired");
   end

endmodule
